// File: rtl/sobel_grad_pipe.sv
// sobel_grad_pipe: 3-stage Sobel magnitude/direction pipeline with ready/valid stall; SOBEL_GRAD_THRESH_EN adds i_low_thresh suppression
module sobel_grad_pipe #(
  parameter int NBIT = 16,
  parameter int MAG_MODE = 0,
  parameter int TAN_LO_NUM = 13,
  parameter int TAN_HI_NUM = 77
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic signed [NBIT-1:0] gx,
  input  logic signed [NBIT-1:0] gy,
`ifdef SOBEL_GRAD_THRESH_EN
  input  logic [NBIT-1:0]        i_low_thresh,
`endif
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [NBIT-1:0]        o_mag,
  output logic [1:0]             o_dir,
  output logic                   o_sat
);
  logic adv, v1, v2, s1, sup;
  logic [NBIT-1:0] ax_n, ay_n, ax, ay, mx_n, mn_n, mx, mn, mag_c;
  logic [NBIT+6:0] pa, pb, pc;
  logic [NBIT:0] sum;
  logic [1:0] dir_n, d2;
  assign adv = i_ready | ~o_valid;
  assign o_ready = adv | ~i_rst_n;
  always_comb begin
    ax_n = gx[NBIT-1] ? NBIT'(-gx) : NBIT'(gx);
    ay_n = gy[NBIT-1] ? NBIT'(-gy) : NBIT'(gy);
    mx_n = ax >= ay ? ax : ay;
    mn_n = ax >= ay ? ay : ax;
    pa = {2'b0, ay, 5'b0};
    pb = (NBIT+7)'(ax) * (NBIT+7)'(TAN_LO_NUM);
    pc = (NBIT+7)'(ax) * (NBIT+7)'(TAN_HI_NUM);
    dir_n = pa <= pb ? 2'd0 : pa >= pc ? 2'd2 : s1 ? 2'd3 : 2'd1;
    sum = MAG_MODE == 1 ? {1'b0, mx} + {1'b0, mn} : {1'b0, mx} + {2'b0, mn[NBIT-1:1]};
    mag_c = sum[NBIT] ? '1 : sum[NBIT-1:0];
`ifdef SOBEL_GRAD_THRESH_EN
    sup = mag_c < i_low_thresh;
`else
    sup = 1'b0;
`endif
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      {v1, v2, o_valid, o_sat, s1} <= '0;
      {ax, ay, mx, mn, o_mag} <= '0;
      {d2, o_dir} <= '0;
    end else if (adv) begin
      v1 <= i_valid;
      ax <= ax_n;
      ay <= ay_n;
      s1 <= gx[NBIT-1] ^ gy[NBIT-1];
      v2 <= v1;
      mx <= mx_n;
      mn <= mn_n;
      d2 <= dir_n;
      o_valid <= v2;
      o_mag <= sup ? '0 : mag_c;
      o_dir <= sup ? 2'd0 : d2;
      o_sat <= sum[NBIT] & ~sup;
    end
  end
endmodule

// File: tb/tb_sobel_grad_pipe.sv
// tb_sobel_grad_pipe: directed table plus stall, reset and threshold sequences for both magnitude modes
module tb_sobel_grad_pipe;
  logic clk = 0, rst_n, i_valid, i_ready;
  logic signed [15:0] gx, gy;
  logic [15:0] thr;
  logic r0, r1, v0, v1, s0, s1;
  logic [15:0] m0, m1;
  logic [1:0] d0, d1;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  sobel_grad_pipe #(.MAG_MODE(0)) u0 (.i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(r0),
    .gx(gx), .gy(gy),
`ifdef SOBEL_GRAD_THRESH_EN
    .i_low_thresh(thr),
`endif
    .o_valid(v0), .i_ready(i_ready), .o_mag(m0), .o_dir(d0), .o_sat(s0));
  sobel_grad_pipe #(.MAG_MODE(1)) u1 (.i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(r1),
    .gx(gx), .gy(gy),
`ifdef SOBEL_GRAD_THRESH_EN
    .i_low_thresh(thr),
`endif
    .o_valid(v1), .i_ready(i_ready), .o_mag(m1), .o_dir(d1), .o_sat(s1));
  typedef struct {
    int gx, gy, mag0, dir, mag1, sat1;
  } vec_t;
  vec_t vt[10];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int idx, oidx, held;
    bit acc;
    vt[0] = '{300, 100, 350, 0, 400, 0};
    vt[1] = '{100, 100, 150, 1, 200, 0};
    vt[2] = '{-100, 100, 150, 3, 200, 0};
    vt[3] = '{0, 50, 50, 2, 50, 0};
    vt[4] = '{0, 0, 0, 0, 0, 0};
    vt[5] = '{-32768, -32768, 49152, 1, 65535, 1};
    vt[6] = '{32767, -32768, 49151, 3, 65535, 0};
    vt[7] = '{32, 13, 38, 0, 45, 0};
    vt[8] = '{32, 77, 93, 2, 109, 0};
    vt[9] = '{-1, 0, 1, 0, 1, 0};
    rst_n = 0; i_valid = 0; i_ready = 1; gx = 0; gy = 0; thr = 0;
    #1;
    chk("ready_in_reset", int'(r0), 1);
    tick();
    chk("rst_valid", int'(v0), 0);
    chk("rst_mag", int'(m0), 0);
    chk("rst_dir", int'(d0), 0);
    chk("rst_sat", int'(s1), 0);
    rst_n = 1;
    tick();
    for (int i = 0; i < 12; i++) begin
      i_valid = i < 10;
      if (i < 10) begin
        gx = 16'(vt[i].gx);
        gy = 16'(vt[i].gy);
      end
      tick();
      if (i >= 2) begin
        chk($sformatf("vec%0d_valid", i-2), int'(v0), 1);
        chk($sformatf("vec%0d_mag0", i-2), int'(m0), vt[i-2].mag0);
        chk($sformatf("vec%0d_dir0", i-2), int'(d0), vt[i-2].dir);
        chk($sformatf("vec%0d_sat0", i-2), int'(s0), 0);
        chk($sformatf("vec%0d_mag1", i-2), int'(m1), vt[i-2].mag1);
        chk($sformatf("vec%0d_dir1", i-2), int'(d1), vt[i-2].dir);
        chk($sformatf("vec%0d_sat1", i-2), int'(s1), vt[i-2].sat1);
      end
    end
    i_valid = 0;
    repeat (3) tick();
    chk("drain_valid", int'(v0), 0);
    idx = 0; oidx = 0; held = 0;
    for (int c = 0; c < 60 && oidx < 10; c++) begin
      i_ready = !(c >= 5 && c < 9);
      i_valid = idx < 10;
      gx = 16'(100 + idx);
      gy = 0;
      #1;
      if (c == 5) held = int'(m0);
      if (c >= 5 && c < 9) begin
        chk($sformatf("stall%0d_oready", c), int'(r0), 0);
        chk($sformatf("stall%0d_valid", c), int'(v0), 1);
        chk($sformatf("stall%0d_mag", c), int'(m0), held);
      end
      if (v0 && i_ready) begin
        chk($sformatf("stream%0d_mag", oidx), int'(m0), 100 + oidx);
        chk($sformatf("stream%0d_dir", oidx), int'(d0), 0);
        oidx++;
      end
      acc = i_valid && r0;
      @(posedge clk);
      if (acc) idx++;
      #1;
    end
    chk("stream_in_count", idx, 10);
    chk("stream_out_count", oidx, 10);
    i_valid = 0; i_ready = 1;
    tick();
    chk("stream_no_dup", int'(v0), 0);
    for (int k = 0; k < 3; k++) begin
      i_valid = 1; gx = 16'(k + 1); gy = 0;
      tick();
    end
    i_valid = 0; rst_n = 0;
    tick();
    chk("midrst_valid0", int'(v0), 0);
    chk("midrst_valid1", int'(v1), 0);
    rst_n = 1;
    i_valid = 1; gx = 77; gy = 0;
    tick();
    i_valid = 0;
    chk("post_rst_lat1", int'(v0), 0);
    tick();
    chk("post_rst_lat2", int'(v0), 0);
    tick();
    chk("post_rst_valid", int'(v0), 1);
    chk("post_rst_mag", int'(m0), 77);
    tick();
    chk("post_rst_single", int'(v0), 0);
`ifdef SOBEL_GRAD_THRESH_EN
    thr = 200;
    i_valid = 1; gx = 100; gy = 50;
    tick();
    gx = 300; gy = 100;
    tick();
    i_valid = 0;
    tick();
    chk("thr_low_valid", int'(v0), 1);
    chk("thr_low_mag", int'(m0), 0);
    chk("thr_low_dir", int'(d0), 0);
    chk("thr_low_mag1", int'(m1), 0);
    tick();
    chk("thr_hi_valid", int'(v0), 1);
    chk("thr_hi_mag", int'(m0), 350);
    chk("thr_hi_dir", int'(d0), 0);
    thr = 0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
